// File: rtl/image_loader.sv
// ----------------------------------------------------------------------------
// image_loader
//
// Upstream feeder for the image-filtering datapath. It accepts an 8-bit
// pixel stream over a valid/ready handshake and packs four consecutive bytes
// into one 32-bit word. Each word is written into the shared 128-word data
// memory, starting at BASE_ADDR. A short image can be closed early with
// in_last. Completion is signalled by a one-cycle done pulse.
//
// Parameters:
//   BASE_ADDR  first memory word written (0..127)
//   WORDS      number of words per image (1..128)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   start       begin a load (sampled only in IDLE)
//   in_valid    pixel byte present
//   in_data     pixel byte
//   in_last     marks the final byte of a short image
//   in_ready    loader accepts a byte this cycle (FILL)
//   mem_wr      memory write strobe, one cycle per word
//   mem_addr    word address, (BASE_ADDR + word_count) mod 128
//   mem_wrData  packed word, lane k = bits [8k+7:8k]
//   busy        high in FILL and WRITE
//   done        one-cycle completion pulse
//   word_count  words written in the current or last load
//   checksum    mod-256 sum of accepted bytes
//
// Optional feature macro: IMAGE_LOADER_CKSUM_EN
//   When it is defined, the checksum adder is built.
//   When it is undefined, checksum is tied to 0.
// ----------------------------------------------------------------------------
module image_loader #(
    parameter int BASE_ADDR = 0,
    parameter int WORDS     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_wr,
    output logic [6:0]  mem_addr,
    output logic [31:0] mem_wrData,
    output logic        busy,
    output logic        done,
    output logic [7:0]  word_count,
    output logic [7:0]  checksum
);

    localparam logic [6:0] BASE7  = 7'(BASE_ADDR);
    localparam logic [7:0] WORDS8 = 8'(WORDS);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] buf_q, buf_d;
    logic        last_q, last_d;
    logic [7:0]  word_count_q, word_count_d;
    logic [6:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wrData_q, mem_wrData_d;

    logic        accept;
    logic [31:0] buf_ins;

    assign accept = (state_q == FILL) && in_valid;

    // Current byte dropped into its lane. The other lanes keep the partial word.
    // The buffer is zeroed at every word boundary, so lanes above the current
    // one are already zero when a word is closed early by in_last.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign buf_ins[8*gi +: 8] = (lane_q == 2'(gi)) ? in_data : buf_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        buf_d        = buf_q;
        last_d       = last_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wrData_d = mem_wrData_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_count_d = '0;
                    lane_d       = '0;
                    buf_d        = '0;
                    last_d       = 1'b0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (lane_q == 2'd3 || in_last) begin
                        // Word complete. Register address and data for the
                        // WRITE cycle so that both are stable for the whole cycle.
                        mem_wrData_d = buf_ins;
                        mem_addr_d   = BASE7 + word_count_q[6:0];
                        last_d       = in_last;
                        buf_d        = '0;
                        lane_d       = '0;
                        state_d      = WRITE;
                    end else begin
                        buf_d  = buf_ins;
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + 8'd1;
                if (last_q || (word_count_q + 8'd1 == WORDS8)) begin
                    state_d = DONE;
                end else begin
                    state_d = FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            buf_q        <= '0;
            last_q       <= 1'b0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            mem_wrData_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            buf_q        <= buf_d;
            last_q       <= last_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wrData_q <= mem_wrData_d;
        end
    end

    assign in_ready   = (state_q == FILL);
    assign mem_wr     = (state_q == WRITE);
    assign busy       = (state_q == FILL) || (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign mem_addr   = mem_addr_q;
    assign mem_wrData = mem_wrData_q;
    assign word_count = word_count_q;

`ifdef IMAGE_LOADER_CKSUM_EN
    logic [7:0] checksum_q, checksum_d;

    // Only accepted bytes are summed. Zero padding never enters the sum.
    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// ----------------------------------------------------------------------------
// Directed testbench for image_loader. Three instances cover three parameter
// sets. All three share the stream inputs, and each has its own start input:
//   u_a : BASE_ADDR=0,   WORDS=2
//   u_b : BASE_ADDR=0,   WORDS=4  (short image)
//   u_c : BASE_ADDR=127, WORDS=2  (address wrap)
// ----------------------------------------------------------------------------
module tb_image_loader;

`ifdef IMAGE_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b0;
    logic [2:0]  start_v  = 3'b000;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_last  = 1'b0;

    logic [2:0]  rdy_v, wr_v, busy_v, done_v;
    logic [6:0]  addr_v [3];
    logic [31:0] data_v [3];
    logic [7:0]  wc_v   [3];
    logic [7:0]  ck_v   [3];

    image_loader #(.BASE_ADDR(0), .WORDS(2)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(rdy_v[0]),
        .mem_wr(wr_v[0]), .mem_addr(addr_v[0]), .mem_wrData(data_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .word_count(wc_v[0]),
        .checksum(ck_v[0]));

    image_loader #(.BASE_ADDR(0), .WORDS(4)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(rdy_v[1]),
        .mem_wr(wr_v[1]), .mem_addr(addr_v[1]), .mem_wrData(data_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .word_count(wc_v[1]),
        .checksum(ck_v[1]));

    image_loader #(.BASE_ADDR(127), .WORDS(2)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(rdy_v[2]),
        .mem_wr(wr_v[2]), .mem_addr(addr_v[2]), .mem_wrData(data_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .word_count(wc_v[2]),
        .checksum(ck_v[2]));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor, sampled on the falling edge
    logic [6:0]  log_addr [$];
    logic [31:0] log_data [$];
    int done_cnt    = 0;
    int done_cyc    = 0;
    int last_wr_cyc = 0;
    int rdy_in_wr   = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (wr_v[d] === 1'b1) begin
                log_addr.push_back(addr_v[d]);
                log_data.push_back(data_v[d]);
                last_wr_cyc = cyc;
                if (rdy_v[d] !== 1'b0) rdy_in_wr++;
                $display("write dut%0d addr=%0d data=%08h cyc=%0d", d, addr_v[d], data_v[d], cyc);
            end
            if (done_v[d] === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                $display("done  dut%0d word_count=%0d checksum=%02h cyc=%0d", d, wc_v[d], ck_v[d], cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_d(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_a(input int i);
        return (i < log_addr.size()) ? 32'(log_addr[i]) : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt  = 0;
        rdy_in_wr = 0;
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    // Offer one byte and hold it until it is accepted, then idle for 'gap' cycles.
    task automatic send(input int d, input logic [7:0] b, input logic l, input int gap);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy_v[d] === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_v[d] === 1'b0 && done_v[d] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (!ok) chk("idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        // Power-up reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy_v[0]), 32'd0);
        chk("rst_wr",    32'(wr_v[0]),  32'd0);
        chk("rst_busy",  32'(busy_v[0]), 32'd0);
        chk("rst_done",  32'(done_v[0]), 32'd0);
        chk("rst_addr",  32'(addr_v[0]), 32'd0);
        chk("rst_data",  data_v[0],     32'd0);
        chk("rst_wc",    32'(wc_v[0]),  32'd0);
        chk("rst_ck",    32'(ck_v[0]),  32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset asserted mid-FILL after 2 bytes
        clear_log();
        pulse_start(0);
        send(0, 8'h11, 1'b0, 0);
        send(0, 8'h22, 1'b0, 0);
        chk("mid_busy_before", 32'(busy_v[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rdy_v[0]), 32'd0);
        chk("mid_rst_busy",  32'(busy_v[0]), 32'd0);
        chk("mid_rst_wc",    32'(wc_v[0]),  32'd0);
        chk("mid_rst_ck",    32'(ck_v[0]),  32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_no_write", 32'(log_addr.size()), 32'd0);
        chk("mid_idle_ready", 32'(rdy_v[0]), 32'd0);

        // Full load without gaps: bytes 01..08
        clear_log();
        pulse_start(0);
        for (int i = 1; i <= 8; i++) send(0, 8'(i), 1'b0, 0);
        wait_idle(0);
        chk("full_nwr",   32'(log_addr.size()), 32'd2);
        chk("full_a0",    log_a(0), 32'd0);
        chk("full_d0",    log_d(0), 32'h04030201);
        chk("full_a1",    log_a(1), 32'd1);
        chk("full_d1",    log_d(1), 32'h08070605);
        chk("full_ndone", 32'(done_cnt), 32'd1);
        chk("full_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
        chk("full_wc",    32'(wc_v[0]), 32'd2);
        chk("full_ck",    32'(ck_v[0]), CK_EN ? 32'h24 : 32'h0);

        // The same load, with in_valid toggling between bytes
        clear_log();
        pulse_start(0);
        for (int i = 1; i <= 8; i++) send(0, 8'(i), 1'b0, 1);
        wait_idle(0);
        chk("gap_nwr", 32'(log_addr.size()), 32'd2);
        chk("gap_d0",  log_d(0), 32'h04030201);
        chk("gap_d1",  log_d(1), 32'h08070605);
        chk("gap_rdy_in_wr", 32'(rdy_in_wr), 32'd0);
        chk("gap_wc",  32'(wc_v[0]), 32'd2);

        // Short image: AA..AF, with in_last on AF
        clear_log();
        pulse_start(1);
        for (int i = 0; i < 6; i++) send(1, 8'(8'hAA + i), (i == 5), 0);
        wait_idle(1);
        chk("short_nwr",   32'(log_addr.size()), 32'd2);
        chk("short_a0",    log_a(0), 32'd0);
        chk("short_d0",    log_d(0), 32'hADACABAA);
        chk("short_a1",    log_a(1), 32'd1);
        chk("short_d1",    log_d(1), 32'h0000AFAE);
        chk("short_ndone", 32'(done_cnt), 32'd1);
        chk("short_wc",    32'(wc_v[1]), 32'd2);
        chk("short_ck",    32'(ck_v[1]), CK_EN ? 32'h0B : 32'h0);

        // Address wrap: BASE_ADDR=127
        clear_log();
        pulse_start(2);
        for (int i = 1; i <= 8; i++) send(2, 8'(i), 1'b0, 0);
        wait_idle(2);
        chk("wrap_nwr", 32'(log_addr.size()), 32'd2);
        chk("wrap_a0",  log_a(0), 32'd127);
        chk("wrap_a1",  log_a(1), 32'd0);
        chk("wrap_d1",  log_d(1), 32'h08070605);

        // start pulses during FILL and during DONE are both ignored
        clear_log();
        pulse_start(0);
        send(0, 8'h01, 1'b0, 0);
        send(0, 8'h02, 1'b0, 0);
        pulse_start(0);
        for (int i = 3; i <= 8; i++) send(0, 8'(i), 1'b0, 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done_v[0] === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("ign_done_seen", 32'(seen), 32'd1);
            start_v[0] = 1'b1;
            @(posedge clk); #1;
            start_v[0] = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("ign_busy",  32'(busy_v[0]), 32'd0);
        chk("ign_wc",    32'(wc_v[0]), 32'd2);
        chk("ign_ndone", 32'(done_cnt), 32'd1);
        chk("ign_nwr",   32'(log_addr.size()), 32'd2);
        chk("ign_d0",    log_d(0), 32'h04030201);
        chk("ign_d1",    log_d(1), 32'h08070605);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_loader.md
# image_loader

Upstream feeder for the image-filtering datapath. Accepts an 8-bit pixel stream over a valid/ready handshake, packs four consecutive bytes into one 4-byte memory word, and writes the words into the shared 128-word data memory (7-bit address, four 8-bit lanes), starting at a base address. The filtering datapath then reads them through its X/Y/Z address paths. It runs before the filter controller is started and signals completion with a one-cycle `done`.

## Interface
Parameters:
- `BASE_ADDR`, default 0: first memory word written (0–127).
- `WORDS`, default 64: number of words per image (1–128).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `in_valid`  in  1  pixel byte present.
- `in_data`  in  8  pixel byte.
- `in_last`  in  1  qualifies the final byte of a short image.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_wr`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  7  word address.
- `mem_wrData`  out  32  packed word; lane k is bits [8k+7:8k].
- `busy`  out  1  high in FILL and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `word_count`  out  8  words written in the current or last load.
- `checksum`  out  8  running byte sum (see Configuration).

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE:
  - `in_ready`=0.
  - When `start`=1, clear `word_count`, the lane counter and `checksum`, then go to FILL.
- FILL:
  - `in_ready`=1. A byte is accepted when `in_valid`&`in_ready` at the edge.
  - The first accepted byte of a word goes to lane 0, then lanes 1, 2, 3 in order.
  - On acceptance of the lane-3 byte, or of any byte with `in_last`=1: latch the word, zero-fill any unwritten higher lanes, and go to WRITE.
- WRITE:
  - `mem_wr`=1, `in_ready`=0 for exactly one cycle.
  - `mem_addr` = (`BASE_ADDR` + `word_count`) mod 128.
  - `word_count` increments at the end of the cycle.
  - If the written word was the `WORDS`-th, or was closed by `in_last`: go to DONE. Otherwise go to FILL.
- DONE: `done`=1 for one cycle, then IDLE.
- `in_last` on a byte that is also the last byte of word `WORDS` has no additional effect.
- Bytes offered outside FILL are not accepted; the source must hold them.
- `start` while busy or in DONE is ignored.
- `word_count` holds its final value in IDLE until the next `start`.
- Address wrap: base 126 with 4 words writes addresses 126, 127, 0, 1.

## Timing
- All outputs reset to 0: `in_ready`, `mem_wr`, `mem_addr`, `mem_wrData`, `busy`, `done`, `word_count`, `checksum`.
- The state resets to IDLE.
- `start` at edge n → FILL and `in_ready`=1 in cycle n+1.
- With `in_valid` held high, bytes are accepted on 4 consecutive edges. The WRITE cycle follows immediately, so throughput is 4 bytes per 5 cycles.
- `mem_addr` and `mem_wrData` are registered and stable for the whole WRITE cycle. Memory samples them at the end of that cycle.
- `done` is asserted in the cycle after the final WRITE.
- Reset asserted mid-load:
  - Immediately returns to IDLE with outputs cleared.
  - A partially filled word is discarded and never written.
  - Words already written remain in memory.

## Configuration
- `IMAGE_LOADER_CKSUM_EN` defined: `checksum` = mod-256 sum of every accepted byte in the current load. Zero-padded lanes are not added. The value is final when `done` is asserted and holds until the next `start`.
- Not defined: `checksum` is tied to 0 and no adder is built.

## Test plan
- Reset/idle: assert `rst`=0 mid-FILL after 2 bytes → all outputs 0, state IDLE. After release, no `mem_wr` occurs without `start`.
- Full load:
  - Stimulus: `BASE_ADDR`=0, `WORDS`=2, bytes 01..08 streamed with no gaps.
  - Required writes: addr 0 = 0x04030201, addr 1 = 0x08070605.
  - Required end state: `done` 1 cycle after the second write, `word_count`=2, `checksum`=0x24 (if enabled).
- Backpressure/gaps: `in_valid` toggles 1,0,1,0… → same data as the gap-free run. `in_ready`=0 during each WRITE cycle; no byte is lost or duplicated.
- Short image: `WORDS`=4, 6 bytes AA..AF with `in_last` on AF → writes 0xADACABAA then 0x0000AFAE, `done`, `word_count`=2.
- Wrap: `BASE_ADDR`=127, `WORDS`=2 → writes at addresses 127 then 0.
- Ignored start: pulse `start` during FILL and during DONE → no restart, `word_count` not cleared, exactly one `done` per load.
